// File: rtl/control_sequencer.sv
// control_sequencer: one-hot T-step generator with memory-wait stalls,
// early instruction end, stop-at-boundary halt and restart.
// Latency: all outputs registered; IDLE/HALT -> T0 one cycle after run is sampled.
// Backpressure: mem_read without mem_done holds the current step (WAIT_MEM).
// Optional feature macro: SEQ_MEM_TIMEOUT_EN (bounded memory wait, sticky flag).
//
// Ports:
//   i_clock        clock, all state changes on posedge
//   i_clear        asynchronous active-low reset (back to IDLE)
//   i_run          start from IDLE / resume from HALT (level)
//   i_stop         request halt at the next instruction boundary (level)
//   i_end_instr    current step is the last of this instruction
//   i_mem_read     current step issues a memory read
//   i_mem_done     memory read data valid this cycle
//   o_step         one-hot current T-step, zero when not running
//   o_step_num     binary index of current step
//   o_busy         RUN or WAIT_MEM
//   o_halted       HALT
//   o_instr_done   one-cycle pulse after an instruction's final step
//   o_mem_timeout  sticky memory-timeout flag (0 without SEQ_MEM_TIMEOUT_EN)
module control_sequencer #(
  parameter  int STEPS   = 8,
  parameter  int TIMEOUT = 16,
  localparam int SW      = $clog2(STEPS)
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_stop,
  input  logic             i_end_instr,
  input  logic             i_mem_read,
  input  logic             i_mem_done,
  output logic [STEPS-1:0] o_step,
  output logic [SW-1:0]    o_step_num,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_instr_done,
  output logic             o_mem_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [STEPS-1:0] STEP_T0 = {{(STEPS-1){1'b0}}, 1'b1};

  if (STEPS < 2 || STEPS > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("control_sequencer: STEPS must be 2..16 and TIMEOUT >= 1");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_nxt_state;
  logic [SW-1:0]    r_step_num;
  logic [SW-1:0]    w_nxt_num;
  logic [STEPS-1:0] r_step;
  logic             r_stop_lat;
  logic             w_nxt_stop;
  logic             r_busy;
  logic             r_halted;
  logic             r_instr_done;
  logic             w_nxt_done;
  logic             w_complete;
  logic             w_boundary;
  logic             w_stop_eff;
  logic             w_nxt_active;

  // A step completes when no read is pending or the read returns this cycle.
  assign w_complete = ((r_state == ST_RUN) && (!i_mem_read || i_mem_done)) ||
                      ((r_state == ST_WAIT) && i_mem_done);
  // end_instr only matters on the cycle the step actually completes.
  assign w_boundary = w_complete &&
                      (i_end_instr || (r_step_num == SW'(STEPS - 1)));
  // A stop arriving on the boundary cycle itself is honoured too.
  assign w_stop_eff = r_stop_lat || i_stop;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_nxt_cnt;
  logic          r_mem_to;
  logic          w_timeout;

  // Fires on the TIMEOUT-th WAIT_MEM cycle that sees no mem_done.
  assign w_timeout = (r_state == ST_WAIT) && !i_mem_done &&
                     (r_wait_cnt == CW'(TIMEOUT - 1));
  assign w_nxt_cnt = ((r_state == ST_WAIT) && !w_timeout && !i_mem_done) ?
                     r_wait_cnt + 1'b1 : '0;

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_wait_cnt <= '0;
      r_mem_to   <= 1'b0;
    end else begin
      r_wait_cnt <= w_nxt_cnt;
      if (w_timeout) r_mem_to <= 1'b1;
    end
  end

  assign o_mem_timeout = r_mem_to;
`else
  assign o_mem_timeout = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_num   = r_step_num;
    w_nxt_stop  = r_stop_lat;
    w_nxt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_nxt_state = ST_RUN;
          w_nxt_num   = '0;
        end
      end
      ST_RUN, ST_WAIT: begin
        w_nxt_stop = r_stop_lat || i_stop;
        if (w_boundary) begin
          w_nxt_done  = 1'b1;
          w_nxt_num   = '0;
          w_nxt_stop  = 1'b0;
          w_nxt_state = w_stop_eff ? ST_HALT : ST_RUN;
        end else if (w_complete) begin
          w_nxt_num   = r_step_num + 1'b1;
          w_nxt_state = ST_RUN;
        end else if (r_state == ST_RUN) begin
          w_nxt_state = ST_WAIT;
        end
`ifdef SEQ_MEM_TIMEOUT_EN
        // Abandoned instruction: no instr_done, pending stop is moot.
        if (w_timeout) begin
          w_nxt_state = ST_HALT;
          w_nxt_num   = '0;
          w_nxt_stop  = 1'b0;
        end
`endif
      end
      default: begin // ST_HALT
        if (i_run && !i_stop) begin
          w_nxt_state = ST_RUN;
          w_nxt_num   = '0;
        end
      end
    endcase
  end

  assign w_nxt_active = (w_nxt_state == ST_RUN) || (w_nxt_state == ST_WAIT);

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state      <= ST_IDLE;
      r_step_num   <= '0;
      r_step       <= '0;
      r_stop_lat   <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_instr_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_step_num   <= w_nxt_num;
      r_step       <= w_nxt_active ? (STEP_T0 << w_nxt_num) : '0;
      r_stop_lat   <= w_nxt_stop;
      r_busy       <= w_nxt_active;
      r_halted     <= (w_nxt_state == ST_HALT);
      r_instr_done <= w_nxt_done;
    end
  end

  assign o_step       = r_step;
  assign o_step_num   = r_step_num;
  assign o_busy       = r_busy;
  assign o_halted     = r_halted;
  assign o_instr_done = r_instr_done;

endmodule
